// File: rtl/sample_pkg.sv
// Shared sizing constants and FSM encoding for the sample gather block.
package sample_pkg;

    localparam int unsigned DATAWIDTH_DEF = 16;
    localparam int unsigned NUM_SLOTS_DEF = 8;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/gather_slot.sv
// One bank slot: a sample register with synchronous clear and a zero-load option.
module gather_slot #(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_zero,
    input  logic [DATAWIDTH-1:0] i_d,
    output logic [DATAWIDTH-1:0] o_q
);

    logic [DATAWIDTH-1:0] r_q;

    // Load either the incoming sample or zero; otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_zero ? '0 : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sample_gather.sv
// Serial-to-parallel gatherer: collects up to eight signed samples into a bank,
// closes the bank when full or on flush, and holds it until the consumer acks.
module sample_gather
    import sample_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATAWIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic signed [DATAWIDTH-1:0] a,
    output logic signed [DATAWIDTH-1:0] b,
    output logic signed [DATAWIDTH-1:0] c,
    output logic signed [DATAWIDTH-1:0] d,
    output logic signed [DATAWIDTH-1:0] e,
    output logic signed [DATAWIDTH-1:0] f,
    output logic signed [DATAWIDTH-1:0] g,
    output logic signed [DATAWIDTH-1:0] h,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_valid,
    input  logic                        out_ack
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLOTS - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_close;
    logic [CNT_W-1:0]   w_close_cnt;
    logic [NUM_SLOTS-1:0] w_load;
    logic [NUM_SLOTS-1:0] w_zero;
    logic [DATAWIDTH-1:0] w_slot_q [NUM_SLOTS];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Accept/close decode: a bank closes on the last accept or on a flush that has data behind it
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_close     = 1'b0;
        w_close_cnt = CNT_W'(r_idx);
        if (r_state == ST_FILL) begin
            if (w_accept && ((r_idx == IDX_LAST) || flush)) begin
                w_close     = 1'b1;
                w_close_cnt = CNT_W'(r_idx) + CNT_W'(1);
            end else if (!w_accept && flush && (r_idx != '0)) begin
                w_close     = 1'b1;
                w_close_cnt = CNT_W'(r_idx);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FILL: if (w_close) w_next_state = ST_HOLD;
            ST_HOLD: if (out_ack) w_next_state = ST_FILL;
            default: w_next_state = ST_FILL;
        endcase
    end

    // Output logic: ready only while filling and never during reset
    always_comb begin
        in_ready = (r_state == ST_FILL) && !rst;
    end

    // Slot index, bank count and valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if ((r_state == ST_HOLD) && out_ack) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_close) begin
                r_out_count <= w_close_cnt;
            end
            r_out_valid <= (w_next_state == ST_HOLD);
        end
    end

    // Per-slot control: the addressed slot takes the sample, slots past the bank end are zeroed on close
    for (genvar i = 0; i < int'(NUM_SLOTS); i++) begin : g_slot
        logic w_sel;
        logic w_clr;
        assign w_sel     = w_accept && (r_idx == IDX_W'(i));
        assign w_clr     = w_close && (CNT_W'(i) >= w_close_cnt);
        assign w_load[i] = w_sel || w_clr;
        assign w_zero[i] = w_clr && !w_sel;

        gather_slot #(
            .DATAWIDTH (DATAWIDTH)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[i]),
            .i_zero (w_zero[i]),
            .i_d    (in_data),
            .o_q    (w_slot_q[i])
        );
    end

    assign a         = w_slot_q[0];
    assign b         = w_slot_q[1];
    assign c         = w_slot_q[2];
    assign d         = w_slot_q[3];
    assign e         = w_slot_q[4];
    assign f         = w_slot_q[5];
    assign g         = w_slot_q[6];
    assign h         = w_slot_q[7];
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sample_gather.sv
// Directed bench for sample_gather with a bank scoreboard.
module tb_sample_gather;

    typedef struct packed {
        logic [7:0][15:0] v;
        logic [3:0]       cnt;
    } bank_t;

    logic               clk;
    logic               rst;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic signed [15:0] a, b, c, d, e, f, g, h;
    logic [3:0]         out_count;
    logic               out_valid;
    logic               out_ack;

    int    nchk  = 0;
    int    nfail = 0;
    bank_t sbq[$];

    // reference model state
    int    mb[8];
    int    mcnt;
    int    midx;
    bit    mhold;
    bit    mvalid;
    logic  prev_v;

    sample_gather #(.DATAWIDTH(16), .NUM_SLOTS(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_count(out_count), .out_valid(out_valid), .out_ack(out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [15:0] slot(input int k);
        case (k)
            0: return a;  1: return b;  2: return c;  3: return d;
            4: return e;  5: return f;  6: return g;  default: return h;
        endcase
    endfunction

    task automatic close_bank(input int n);
        bank_t nb;
        for (int k = n; k < 8; k++) mb[k] = 0;
        mcnt   = n;
        mhold  = 1'b1;
        mvalid = 1'b1;
        for (int k = 0; k < 8; k++) nb.v[k] = 16'(mb[k]);
        nb.cnt = 4'(n);
        sbq.push_back(nb);
    endtask

    // One clock: check ready, advance the model, clock the DUT, check outputs and scoreboard
    task automatic tick();
        bit    acc;
        bank_t eb;
        #1;
        chk("in_ready", in_ready, (!mhold && !rst));
        if (rst) begin
            for (int k = 0; k < 8; k++) mb[k] = 0;
            mcnt = 0; midx = 0; mhold = 1'b0; mvalid = 1'b0;
        end else if (!mhold) begin
            acc = in_valid;
            if (acc) mb[midx] = int'(in_data);
            if (acc && (midx == 7 || flush)) close_bank(midx + 1);
            else if (!acc && flush && midx != 0) close_bank(midx);
            if (acc) midx = (midx + 1) % 8;
        end else if (out_ack) begin
            mhold = 1'b0; midx = 0; mvalid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, mvalid);
        if (out_valid === 1'b1 && prev_v !== 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_bank", 1, 0);
            end else begin
                eb = sbq.pop_front();
                for (int k = 0; k < 8; k++) chk($sformatf("sb_slot%0d", k), slot(k), $signed(eb.v[k]));
                chk("sb_count", out_count, eb.cnt);
            end
        end
        prev_v = out_valid;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = 16'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    task automatic chk_bank(input string tag, input int ev[8], input int cnt);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_slot%0d", tag, k), slot(k), ev[k]);
        chk({tag, "_count"}, out_count, cnt);
    endtask

    initial begin
        int ev[8];
        int s1[8];
        int s2[16];
        int j;
        int guard;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ack = 1'b0; in_data = '0;
        prev_v = 1'b0; mhold = 1'b0; midx = 0; mcnt = 0; mvalid = 1'b0;
        for (int k = 0; k < 8; k++) mb[k] = 0;
        tick();
        tick();
        ev = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk_bank("reset", ev, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        // full bank
        s1 = '{1, 2, -3, 4, 5, -6, 7, 8};
        for (int k = 0; k < 8; k++) push(s1[k]);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk_bank("full", s1, 8);
        do_ack();
        chk("full_ack_valid", out_valid, 0);
        chk("full_ack_ready", in_ready, 1);

        // partial flush
        push(10); push(-20); push(30);
        flush = 1'b1; tick(); flush = 1'b0;
        ev = '{10, -20, 30, 0, 0, 0, 0, 0};
        chk("pflush_valid", out_valid, 1);
        chk_bank("pflush", ev, 3);
        do_ack();

        // idle flush at idx 0 is ignored
        flush = 1'b1; tick(); flush = 1'b0;
        chk("idle_flush_valid", out_valid, 0);

        // flush coincident with accept
        push(5);
        in_valid = 1'b1; in_data = 16'sd6; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        ev = '{5, 6, 0, 0, 0, 0, 0, 0};
        chk_bank("flacc", ev, 2);

        // hold under pressure
        in_valid = 1'b1; in_data = 16'sd99; flush = 1'b1;
        repeat (5) tick();
        chk_bank("hold", ev, 2);
        chk("hold_in_ready", in_ready, 0);
        flush = 1'b0;
        do_ack();
        chk("hold_ack_valid", out_valid, 0);
        chk("hold_ack_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("hold_99_in_a", a, 99);
        flush = 1'b1; tick(); flush = 1'b0;
        ev = '{99, 0, 0, 0, 0, 0, 0, 0};
        chk_bank("hold_close", ev, 1);
        do_ack();

        // reset mid-fill
        push(11); push(12); push(13); push(14);
        rst = 1'b1; tick(); rst = 1'b0;
        ev = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk_bank("midrst", ev, 0);
        chk("midrst_valid", out_valid, 0);
        for (int k = 0; k < 8; k++) push(32767);
        ev = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        chk_bank("max", ev, 8);
        do_ack();

        // back-to-back banks with ack on first valid cycle
        for (int k = 0; k < 16; k++) s2[k] = $signed(16'($urandom));
        for (int k = 0; k < 8; k++) push(s2[k]);
        chk("b2b_first_valid", out_valid, 1);
        j = 8;
        guard = 0;
        out_ack = 1'b1;
        while (j < 16 && guard < 100) begin
            bit rdy;
            in_valid = 1'b1;
            in_data  = 16'(s2[j]);
            rdy = in_ready;
            tick();
            out_ack = 1'b0;
            if (rdy) j++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 100) chk("b2b_timeout", 1, 0);
        chk("b2b_second_valid", out_valid, 1);
        for (int k = 0; k < 8; k++) ev[k] = s2[8 + k];
        chk_bank("b2b_second", ev, 8);
        do_ack();
        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
